// File: rtl/imm_gen_if.sv
// Valid/ready bus for the immediate generator: instruction+tag in, decoded immediate out.
// master = producer/consumer side, slave = the imm_gen_pipe stage.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: one decode register stage plus an optional skid
// entry so that in_ready comes straight from a flop.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  imm_gen_if.slave  bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t        dec_d;
  ent_t        out_q, skid_q;
  logic        out_vld_q, skid_vld_q;
  logic [31:0] ins;
  logic [31:0] imm32;
  fmt_e        fmt;
  logic        in_xfer;

  assign ins = bus.in_instr;

  always_comb begin
    fmt = FMT_ILL;
    unique case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b0001111, 7'b1110011: fmt = FMT_I;
      7'b0011011:             fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
      7'b0100011:             fmt = FMT_S;
      7'b1100011:             fmt = FMT_B;
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1101111:             fmt = FMT_J;
      7'b0110011:             fmt = FMT_R;
      7'b0111011:             fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:                fmt = FMT_ILL;
    endcase
  end

  // Every format fits in 32 bits; widening to XLEN is a single sign extension.
  always_comb begin
    imm32 = '0;
    unique case (fmt)
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec_d.imm = XLEN'($signed(imm32));
    dec_d.fmt = fmt;
    dec_d.tag = bus.in_tag;
  end

  // With SKID_EN=0 in_ready already requires the out reg to be free, so the skid never fills.
  assign bus.in_ready = SKID_EN ? !skid_vld_q : (!out_vld_q || bus.out_ready);
  assign in_xfer      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (!out_vld_q || bus.out_ready) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else if (in_xfer) begin
        out_q     <= dec_d;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q     <= dec_d;
      skid_vld_q <= 1'b1;
    end
  end

  assign bus.out_valid   = out_vld_q;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = (out_q.fmt == FMT_ILL);
  assign bus.out_tag     = out_q.tag;

endmodule
